// File: rtl/out_channel_pkg.sv
// ----------------------------------------------------------------------------
// out_channel_pkg
// Shared definitions for the out-channel drain block: the drain state
// encoding, default width constants and a small sizing helper.
// Ports: none (package).
// ----------------------------------------------------------------------------
package out_channel_pkg;

    localparam int DEF_MEM_WIDTH   = 12;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        TRAILER = 2'd2,
        DONE    = 2'd3
    } drain_state_e;

    // One extra bit over the pointer width so that "full" (Depth) and
    // "empty" (0) are distinct occupancy values.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/out_channel_drain_if.sv
// ----------------------------------------------------------------------------
// out_channel_drain_if
// Handshake bundle between the interpreter out-channel, the drain block and
// the downstream sink.
//   outValid/outData  : interpreter -> drain, word written by an out instruction
//   outReady          : drain -> interpreter, word accepted this cycle
//   txValid/txData    : drain -> sink, word offered downstream
//   txReady           : sink -> drain, word taken this cycle
// Modports: slave = the drain block, master = the surrounding environment.
// ----------------------------------------------------------------------------
interface out_channel_drain_if
    import out_channel_pkg::*;
#(
    parameter int MemoryElementWidth = DEF_MEM_WIDTH
) ();

    logic                          outValid;
    logic [MemoryElementWidth-1:0] outData;
    logic                          outReady;
    logic                          txValid;
    logic [MemoryElementWidth-1:0] txData;
    logic                          txReady;

    modport slave (
        input  outValid,
        input  outData,
        input  txReady,
        output outReady,
        output txValid,
        output txData
    );

    modport master (
        output outValid,
        output outData,
        output txReady,
        input  outReady,
        input  txValid,
        input  txData
    );

endinterface

// File: rtl/out_fifo_mem.sv
// ----------------------------------------------------------------------------
// out_fifo_mem
// Depth x Width register array with one synchronous write port and one
// combinational read port. No reset: contents are only meaningful behind the
// occupancy tracking in the parent.
//   clock   : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : read data (mem[rd_addr])
// ----------------------------------------------------------------------------
module out_fifo_mem
    import out_channel_pkg::*;
#(
    parameter int Width = DEF_MEM_WIDTH,
    parameter int Depth = DEF_DEPTH
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(Depth)-1:0] wr_addr,
    input  logic [Width-1:0]         wr_data,
    input  logic [$clog2(Depth)-1:0] rd_addr,
    output logic [Width-1:0]         rd_data
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/out_channel_drain.sv
// ----------------------------------------------------------------------------
// out_channel_drain
// Buffers words from the interpreter out-channel in a small FIFO and drains
// them to a downstream sink. Once the interpreter reports it has finished,
// the block flushes the FIFO, optionally appends a checksum trailer word, and
// then raises drained until reset.
//
// Optional feature: define OUT_CHANNEL_CHECKSUM_EN to keep a running modulo
// sum of every accepted word and emit it as one trailer word after the last
// data word.
//
// Ports:
//   clock           : single clock, all state changes on posedge
//   reset           : synchronous active-low reset
//   bus             : out-channel / tx handshake bundle (slave side)
//   programFinished : interpreter finished level, held until reset
//   wordCount       : words accepted since reset, saturating
//   overflow        : sticky, set when a word is offered but not accepted
//   drained         : everything (plus trailer if enabled) delivered
//
// States:
//   RUN     | accepting words from the interpreter
//   FLUSH   | interpreter finished, emptying the FIFO
//   TRAILER | checksum word offered downstream (checksum build only)
//   DONE    | all delivered, held until reset
// ----------------------------------------------------------------------------
module out_channel_drain
    import out_channel_pkg::*;
#(
    parameter int MemoryElementWidth = DEF_MEM_WIDTH,
    parameter int Depth              = DEF_DEPTH,
    parameter int CountWidth         = DEF_COUNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    out_channel_drain_if.slave    bus,
    input  logic                  programFinished,
    output logic [CountWidth-1:0] wordCount,
    output logic                  overflow,
    output logic                  drained
);

    localparam int PtrWidth = $clog2(Depth);
    localparam int OccWidth = occ_width(Depth);
    localparam logic [OccWidth-1:0] OccFull = OccWidth'(Depth);

    drain_state_e                  state;
    logic [PtrWidth-1:0]           wr_ptr;
    logic [PtrWidth-1:0]           rd_ptr;
    logic [PtrWidth-1:0]           rd_ptr_next;
    logic [OccWidth-1:0]           occupancy;
    logic [OccWidth-1:0]           occupancy_next;
    logic                          tx_valid;
    logic [MemoryElementWidth-1:0] tx_data;
    logic                          fifo_full;
    logic                          push;
    logic                          pop;
    logic                          head_bypass;
    logic [MemoryElementWidth-1:0] mem_rd_data;
    logic [MemoryElementWidth-1:0] head_next;
`ifdef OUT_CHANNEL_CHECKSUM_EN
    logic [MemoryElementWidth-1:0] checksum;
`endif

    assign fifo_full    = (occupancy == OccFull);
    assign bus.outReady = (state == RUN) && !fifo_full;
    assign bus.txValid  = tx_valid;
    assign bus.txData   = tx_data;

    assign push = bus.outValid && bus.outReady;
    // The trailer is never counted in occupancy, so only real data pops here.
    assign pop  = tx_valid && bus.txReady && (occupancy != '0);

    assign rd_ptr_next    = rd_ptr + PtrWidth'(pop);
    assign occupancy_next = occupancy + OccWidth'(push) - OccWidth'(pop);

    // The registered head is loaded from the post-edge read pointer. When that
    // slot is the one being written on this same edge (empty FIFO, or the last
    // entry leaving while a new one arrives), the array does not hold it yet,
    // so take the incoming word directly.
    assign head_bypass = push && (wr_ptr == rd_ptr_next);
    assign head_next   = head_bypass ? bus.outData : mem_rd_data;

    out_fifo_mem #(
        .Width (MemoryElementWidth),
        .Depth (Depth)
    ) u_mem (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (bus.outData),
        .rd_addr (rd_ptr_next),
        .rd_data (mem_rd_data)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= RUN;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            wordCount <= '0;
            overflow  <= 1'b0;
            drained   <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
`ifdef OUT_CHANNEL_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            rd_ptr    <= rd_ptr_next;
            occupancy <= occupancy_next;

            if (push) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
                if (wordCount != '1) begin
                    wordCount <= wordCount + CountWidth'(1);
                end
`ifdef OUT_CHANNEL_CHECKSUM_EN
                checksum <= checksum + bus.outData;
`endif
            end

            if (bus.outValid && !bus.outReady) begin
                overflow <= 1'b1;
            end

            // Data-word view of the output stage; TRAILER overrides it below.
            tx_valid <= (occupancy_next != '0);
            tx_data  <= (occupancy_next != '0) ? head_next : '0;

            unique case (state)
                RUN: begin
                    if (programFinished) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (occupancy_next == '0) begin
`ifdef OUT_CHANNEL_CHECKSUM_EN
                        // No pushes outside RUN, so the checksum is final here.
                        state    <= TRAILER;
                        tx_valid <= 1'b1;
                        tx_data  <= checksum;
`else
                        state    <= DONE;
                        drained  <= 1'b1;
`endif
                    end
                end
`ifdef OUT_CHANNEL_CHECKSUM_EN
                TRAILER: begin
                    if (bus.txReady) begin
                        state    <= DONE;
                        drained  <= 1'b1;
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                    end else begin
                        tx_valid <= 1'b1;
                        tx_data  <= checksum;
                    end
                end
`endif
                DONE: begin
                    drained <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
